// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared index helper and source index type for the FIFO drain fabric
package fifo_arb_pkg;

  localparam int FABRIC_N_SRC = 4;

  // Index width that stays at least one bit wide even for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef logic [clog2_min1(FABRIC_N_SRC)-1:0] src_idx_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority find-first: first set req bit at or after start, wrapping
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  int            c;
  logic [IW-1:0] ci;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    ci    = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(start) + k;
      if (c >= N) c = c - N;
      ci = c[IW-1:0];
      if (!found && req[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain_arb.sv
// rtl/fifo_rr_drain_arb.sv - round-robin burst scheduler draining N_REQ registered-dout FIFOs
// onto one valid/ready stream; the FIFO dout registers are the only data storage.
module fifo_rr_drain_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             fifo_empty,
  input  logic [N_REQ*WIDTH-1:0]       fifo_dout,
  output logic [N_REQ-1:0]             fifo_rd_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [clog2_min1(N_REQ)-1:0] out_src,
  output logic                         busy
);

  localparam int            IW        = clog2_min1(N_REQ);
  localparam int            CW        = clog2_min1(BURST + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(BURST);

  logic [IW-1:0] grant;
  logic [IW-1:0] rr_start;
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] pick;
  logic [CW-1:0] burst_cnt;
  logic          slot;
  logic          same_grant;
  logic          rr_found;
  logic          have_pick;
  logic          issue;

  // Search starts just past the current grant so the grant itself is tried last.
  assign rr_start = (grant == LAST_IDX) ? '0 : grant + IW'(1);

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (~fifo_empty),
    .start (rr_start),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign slot       = !out_valid || out_ready;
  assign same_grant = out_valid && (burst_cnt < BURST_MAX) && !fifo_empty[grant];
  assign have_pick  = same_grant || rr_found;
  assign pick       = same_grant ? grant : rr_idx;
  assign issue      = rst_n && slot && have_pick;

  always_comb begin
    fifo_rd_en = '0;
    if (issue) fifo_rd_en[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      grant     <= LAST_IDX;
      burst_cnt <= '0;
    end else if (slot) begin
      if (have_pick) begin
        out_valid <= 1'b1;
        grant     <= pick;
        if (same_grant)
          burst_cnt <= (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + CW'(1);
        else
          burst_cnt <= CW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // The granted FIFO's dout holds until its next pop, so a plain mux stays stable under stall.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant == IW'(i)) out_data = fifo_dout[i*WIDTH +: WIDTH];
  end

  assign out_src = grant;
  assign busy    = out_valid || (|fifo_rd_en);

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// tb/tb_fifo_rr_drain_arb.sv - directed bench for fifo_rr_drain_arb with four registered-dout FIFOs
module tb_fifo_rr_drain_arb;

  localparam int N_REQ  = 4;
  localparam int WIDTH  = 8;
  localparam int BURST  = 4;
  localparam int DEPTH  = 16;
  localparam int TR_LEN = 4096;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       fifo_empty;
  logic [N_REQ*WIDTH-1:0] fifo_dout;
  logic [N_REQ-1:0]       fifo_rd_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [1:0]             out_src;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  logic [N_REQ-1:0] push_en;
  logic [WIDTH-1:0] push_data [N_REQ];
  logic [WIDTH-1:0] mem [N_REQ][DEPTH];
  logic [WIDTH-1:0] dout_q [N_REQ];
  int               cnt [N_REQ];
  int               rp [N_REQ];
  int               wp [N_REQ];
  int               overread = 0;
  int               cyc = 0;

  logic [N_REQ-1:0] tr_rd [TR_LEN];
  logic             tr_v [TR_LEN];
  logic             tr_acc [TR_LEN];
  logic [1:0]       tr_src [TR_LEN];
  logic [WIDTH-1:0] tr_data [TR_LEN];

  int         acc_cyc [$];
  logic [1:0] acc_src [$];
  logic [7:0] acc_data [$];

  fifo_rr_drain_arb #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH),
    .BURST (BURST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Synchronous FIFOs with registered dout; empty updates at the same edge as the pop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i]    <= 0;
        rp[i]     <= 0;
        wp[i]     <= 0;
        dout_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (fifo_rd_en[i]) begin
          if (cnt[i] == 0) overread <= overread + 1;
          dout_q[i] <= mem[i][rp[i]];
          rp[i]     <= (rp[i] + 1) % DEPTH;
        end
        if (push_en[i]) begin
          mem[i][wp[i]] <= push_data[i];
          wp[i]         <= (wp[i] + 1) % DEPTH;
        end
        cnt[i] <= cnt[i] + int'(push_en[i]) - int'(fifo_rd_en[i]);
      end
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_dout  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      fifo_empty[i]                 = (cnt[i] == 0);
      fifo_dout[i*WIDTH +: WIDTH]   = dout_q[i];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < TR_LEN) begin
      tr_rd[cyc]   <= fifo_rd_en;
      tr_v[cyc]    <= out_valid;
      tr_acc[cyc]  <= rst_n && out_valid && out_ready;
      tr_src[cyc]  <= out_src;
      tr_data[cyc] <= out_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    push_en   = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic gather(input int c0, input int c1);
    acc_cyc.delete();
    acc_src.delete();
    acc_data.delete();
    for (int c = c0; c < c1 && c < TR_LEN; c++) begin
      if (tr_acc[c] === 1'b1) begin
        acc_cyc.push_back(c);
        acc_src.push_back(tr_src[c]);
        acc_data.push_back(tr_data[c]);
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    push_en   = '0;
    for (int i = 0; i < N_REQ; i++) push_data[i] = '0;
    step(3);
    checks++;
    if (out_valid !== 1'b0 || fifo_rd_en !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b rd_en=%b busy=%b, required 0 0000 0", out_valid, fifo_rd_en, busy);
    end
    checks++;
    if (out_src !== 2'd3 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_grant: out_src=%0d out_data=%h, required 3 00", out_src, out_data);
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || fifo_rd_en !== 4'b0000 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_empty: %0d active cycles seen, required 0", bad);
    end
  endtask

  task automatic test_single_latency();
    logic [7:0] vals [3];
    int c0, t;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    out_ready = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      push_en      = 4'b0100;
      push_data[2] = vals[k];
      step(1);
    end
    push_en = '0;
    step(8);
    t = -1;
    for (int c = c0; c < cyc; c++)
      if (t < 0 && tr_rd[c] !== 4'b0000) t = c;
    checks++;
    if (t !== c0 + 1) begin
      errors++;
      $display("FAIL single_first_pop: cycle %0d, required %0d", t, c0 + 1);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (tr_rd[t+k] !== 4'b0100 || tr_v[t+k+1] !== 1'b1 || tr_src[t+k+1] !== 2'd2 ||
            tr_data[t+k+1] !== vals[k]) begin
          errors++;
          $display("FAIL single_word%0d: rd_en=%b valid=%b src=%0d data=%h, required 0100 1 2 %h",
                   k, tr_rd[t+k], tr_v[t+k+1], tr_src[t+k+1], tr_data[t+k+1], vals[k]);
        end
      end
      checks++;
      if (tr_rd[t+3] !== 4'b0000 || tr_v[t+4] !== 1'b0) begin
        errors++;
        $display("FAIL single_drained: rd_en=%b valid=%b, required 0000 0", tr_rd[t+3], tr_v[t+4]);
      end
    end
  endtask

  task automatic test_burst_rotation();
    int es [12];
    int n [2];
    int c0, bad_order, bad_gap, s;
    es = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_en      = 4'b0011;
      push_data[0] = 8'(k);
      push_data[1] = 8'(16 + k);
      step(1);
    end
    push_en = '0;
    step(2);
    c0 = cyc;
    out_ready = 1'b1;
    step(20);
    gather(c0, cyc);
    checks++;
    if (acc_src.size() !== 12) begin
      errors++;
      $display("FAIL burst_count: %0d words, required 12", acc_src.size());
    end
    n[0] = 0; n[1] = 0;
    bad_order = 0;
    bad_gap   = 0;
    for (int k = 0; k < 12 && k < acc_src.size(); k++) begin
      s = es[k];
      if (acc_src[k] !== 2'(s) || acc_data[k] !== 8'(s * 16 + n[s])) begin
        bad_order++;
        $display("FAIL burst_word%0d: src=%0d data=%h, required %0d %h", k, acc_src[k], acc_data[k], s, 8'(s * 16 + n[s]));
      end
      n[s]++;
      if (acc_cyc[k] !== c0 + k) bad_gap++;
    end
    checks++;
    if (bad_order !== 0) begin
      errors++;
      $display("FAIL burst_order: %0d wrong words, required 0", bad_order);
    end
    checks++;
    if (bad_gap !== 0) begin
      errors++;
      $display("FAIL burst_back_to_back: %0d off-cycle words, required 0", bad_gap);
    end
  endtask

  task automatic test_backpressure();
    int n [N_REQ];
    int c0, bad, s;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_en      = 4'b1001;
      push_data[0] = 8'(k);
      push_data[3] = 8'(48 + k);
      step(1);
    end
    push_en = '0;
    step(1);
    c0 = cyc;
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;
    step(5);
    out_ready = 1'b1;
    step(20);
    checks++;
    if (tr_src[c0+2] !== 2'd0 || tr_data[c0+2] !== 8'h02) begin
      errors++;
      $display("FAIL stall_word: src=%0d data=%h, required 0 02", tr_src[c0+2], tr_data[c0+2]);
    end
    bad = 0;
    for (int c = c0 + 2; c <= c0 + 6; c++) begin
      if (tr_rd[c] !== 4'b0000 || tr_v[c] !== 1'b1 || tr_acc[c] !== 1'b0) bad++;
      if (c > c0 + 2 && (tr_data[c] !== tr_data[c0+2] || tr_src[c] !== tr_src[c0+2])) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: %0d violations, required 0", bad);
    end
    gather(c0, cyc);
    checks++;
    if (acc_src.size() !== 12) begin
      errors++;
      $display("FAIL bp_count: %0d words, required 12", acc_src.size());
    end
    bad = 0;
    for (int k = 0; k < acc_cyc.size(); k++)
      if (acc_cyc[k] !== c0 + k + ((k >= 2) ? 5 : 0)) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_release_timing: %0d off-cycle words, required 0", bad);
    end
    for (int i = 0; i < N_REQ; i++) n[i] = 0;
    bad = 0;
    for (int k = 0; k < acc_src.size(); k++) begin
      s = int'(acc_src[k]);
      if ((s != 0 && s != 3) || acc_data[k] !== 8'(s * 16 + n[s])) bad++;
      n[s]++;
    end
    checks++;
    if (bad !== 0 || n[0] !== 6 || n[3] !== 6) begin
      errors++;
      $display("FAIL bp_scoreboard: bad=%0d n0=%0d n3=%0d, required 0 6 6", bad, n[0], n[3]);
    end
  endtask

  task automatic test_fairness();
    int c0, n_acc, guard, bad, s, e;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      push_en = 4'b1111;
      for (int i = 0; i < N_REQ; i++) push_data[i] = 8'(i * 16 + k);
      step(1);
    end
    push_en = '0;
    step(1);
    c0    = cyc;
    n_acc = 0;
    guard = 0;
    while (n_acc < 64 && guard < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) n_acc++;
      @(posedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b0;
    step(2);
    checks++;
    if (n_acc !== 64) begin
      errors++;
      $display("FAIL fair_timeout: %0d words in %0d cycles, required 64", n_acc, guard);
    end
    gather(c0, cyc);
    bad = 0;
    for (int k = 0; k < 64 && k < acc_src.size(); k++) begin
      s = (k / 4) % 4;
      e = s * 16 + (k / 16) * 4 + (k % 4);
      if (acc_src[k] !== 2'(s) || acc_data[k] !== 8'(e)) bad++;
    end
    checks++;
    if (bad !== 0 || acc_src.size() !== 64) begin
      errors++;
      $display("FAIL fair_rotation: %0d wrong of %0d words, required 0 of 64", bad, acc_src.size());
    end
    checks++;
    if (fifo_empty !== 4'b1111 || overread !== 0) begin
      errors++;
      $display("FAIL fair_drained: empty=%b overread=%0d, required 1111 0", fifo_empty, overread);
    end
  endtask

  task automatic test_async_reset();
    int c0, bad;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_en      = 4'b0010;
      push_data[1] = 8'(16 + k);
      step(1);
    end
    push_en = '0;
    step(1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL arst_setup: valid=%b src=%0d data=%h, required 1 1 11", out_valid, out_src, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_rd_en !== 4'b0000 || busy !== 1'b0 || out_src !== 2'd3) begin
      errors++;
      $display("FAIL arst_immediate: valid=%b rd_en=%b busy=%b src=%0d, required 0 0000 0 3",
               out_valid, fifo_rd_en, busy, out_src);
    end
    step(2);
    rst_n = 1'b1;
    step(1);
    c0 = cyc;
    out_ready = 1'b1;
    push_en   = 4'b1111;
    for (int i = 0; i < N_REQ; i++) push_data[i] = 8'(i * 16 + 10);
    step(1);
    push_en = '0;
    step(8);
    gather(c0, cyc);
    checks++;
    if (acc_src.size() < 1 || acc_src[0] !== 2'd0 || acc_data[0] !== 8'h0A) begin
      errors++;
      $display("FAIL arst_first_grant: words=%0d src=%0d data=%h, required >=1 0 0a",
               acc_src.size(), (acc_src.size() > 0) ? acc_src[0] : 2'd0,
               (acc_data.size() > 0) ? acc_data[0] : 8'h00);
    end
    bad = 0;
    for (int k = 0; k < acc_src.size(); k++)
      if (acc_src[k] !== 2'(k) || acc_data[k] !== 8'(k * 16 + 10)) bad++;
    checks++;
    if (bad !== 0 || acc_src.size() !== 4) begin
      errors++;
      $display("FAIL arst_refill: %0d wrong of %0d words, required 0 of 4", bad, acc_src.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    push_en   = '0;
    test_reset();
    test_single_latency();
    test_burst_rotation();
    test_backpressure();
    test_fairness();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
